// File: rtl/qam_pkg.sv
// Shared constants and types for the QPSK demodulator slice.
// Symbol framing, FSM state type and symbol bit encodings.
package qam_pkg;

    localparam int SYM_LEN   = 128;
    localparam int BURST_MAX = 32;
    localparam int LEN_W     = 6;

    localparam logic [6:0]       P_FIRST = 7'd0;
    localparam logic [6:0]       P_LAST  = 7'(SYM_LEN - 1);
    localparam logic [LEN_W-1:0] LEN_SAT = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // Symbol bits -> constellation quadrant (sign of I, sign of Q)
    localparam logic [1:0] SYM_PI_NQ = 2'b00;
    localparam logic [1:0] SYM_PI_PQ = 2'b01;
    localparam logic [1:0] SYM_NI_PQ = 2'b11;
    localparam logic [1:0] SYM_NI_NQ = 2'b10;

endpackage

// File: rtl/qam_correlator.sv
// One correlator rail: multiplies the received sample by a reference
// carrier sample and integrates over a symbol window.
// Ports: clk_i, rst_ni, rx_i/ref_i (signed 9b), load_i (start of window),
//        dump_o = running sum including the current product.
module qam_correlator
    import qam_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic signed [8:0]       rx_i,
    input  logic signed [8:0]       ref_i,
    input  logic                    load_i,
    output logic signed [ACC_W-1:0] dump_o
);

    logic signed [17:0]      prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;

    // 18 bits so that -256 * -256 cannot wrap
    assign prod     = rx_i * ref_i;
    assign prod_ext = {{(ACC_W-18){prod[17]}}, prod};
    assign dump_o   = acc_q + prod_ext;
    assign acc_d    = load_i ? prod_ext : dump_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/qam_demod.sv
// Coherent QPSK demodulator with burst framing tracker.
// Ports: clk, reset (async, active low), rx_in, GetSin, GetCos, trans_read
//        in; demod_out/demod_valid, burst_active, burst_end/burst_len out.
module qam_demod
    import qam_pkg::*;
#(
    parameter int               ACC_W  = 24,
    parameter logic [ACC_W-1:0] THRESH = 24'd65536
) (
    input  logic              clk,
    input  logic              reset,
    input  logic signed [8:0] rx_in,
    input  logic signed [8:0] GetSin,
    input  logic signed [8:0] GetCos,
    input  logic [6:0]        trans_read,
    output logic [1:0]        demod_out,
    output logic              demod_valid,
    output logic              burst_active,
    output logic              burst_end,
    output logic [LEN_W-1:0]  burst_len
);

    logic signed [8:0] sin_q;
    logic signed [8:0] cos_q;
    logic [6:0]        p_q;
    logic              dly_vld_q;
    logic              primed_q;
    state_e            state_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [1:0]        out_q;
    logic              valid_q;
    logic              end_q;
    logic [LEN_W-1:0]  len_q;

    logic signed [ACC_W-1:0] i_sum;
    logic signed [ACC_W-1:0] q_sum;
    logic [ACC_W:0]          abs_i;
    logic [ACC_W:0]          abs_q;
    logic [ACC_W:0]          energy;
    logic                    silent;
    logic                    dump;
    logic [1:0]              dec;

    qam_correlator #(.ACC_W(ACC_W)) u_corr_i (
        .clk_i  (clk),
        .rst_ni (reset),
        .rx_i   (rx_in),
        .ref_i  (cos_q),
        .load_i (p_q == P_FIRST),
        .dump_o (i_sum)
    );

    qam_correlator #(.ACC_W(ACC_W)) u_corr_q (
        .clk_i  (clk),
        .rst_ni (reset),
        .rx_i   (rx_in),
        .ref_i  (sin_q),
        .load_i (p_q == P_FIRST),
        .dump_o (q_sum)
    );

    // One extra bit so |most negative| is representable
    assign abs_i = i_sum[ACC_W-1]
                 ? ({1'b0, ~i_sum} + {{ACC_W{1'b0}}, 1'b1})
                 : {1'b0, i_sum};
    assign abs_q = q_sum[ACC_W-1]
                 ? ({1'b0, ~q_sum} + {{ACC_W{1'b0}}, 1'b1})
                 : {1'b0, q_sum};

    assign energy = abs_i + abs_q;
    assign silent = energy < {1'b0, THRESH};
    assign dump   = (p_q == P_LAST) && primed_q;

    // Q == 0 decodes as bit0 = 0
    assign dec[1] = i_sum[ACC_W-1];
    assign dec[0] = !q_sum[ACC_W-1] && (q_sum != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sin_q     <= '0;
            cos_q     <= '0;
            p_q       <= '0;
            dly_vld_q <= 1'b0;
            primed_q  <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            len_q     <= '0;
        end else begin
            sin_q     <= GetSin;
            cos_q     <= GetCos;
            p_q       <= trans_read;
            dly_vld_q <= 1'b1;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            // p_q is only meaningful once it holds a real sample
            if (dly_vld_q && p_q == P_FIRST) begin
                primed_q <= 1'b1;
            end
            if (dump) begin
                unique case (state_q)
                    IDLE: begin
                        if (!silent) begin
                            state_q <= BURST;
                            cnt_q   <= {{(LEN_W-1){1'b0}}, 1'b1};
                            out_q   <= dec;
                            valid_q <= 1'b1;
                        end
                    end
                    BURST: begin
                        if (silent) begin
                            state_q <= IDLE;
                            len_q   <= cnt_q;
                            end_q   <= 1'b1;
                        end else begin
                            if (cnt_q != LEN_SAT) begin
                                cnt_q <= cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
                            end
                            out_q   <= dec;
                            valid_q <= 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign demod_out    = out_q;
    assign demod_valid  = valid_q;
    assign burst_active = (state_q == BURST);
    assign burst_end    = end_q;
    assign burst_len    = len_q;

endmodule

// File: tb/tb_qam_demod.sv
// Self-checking bench for qam_demod: modulator model drives the carrier
// references and received waveform; expected strobes come from a queue.
module tb_qam_demod;

    logic              clk = 1'b0;
    logic              reset;
    logic signed [8:0] rx_in;
    logic signed [8:0] GetSin;
    logic signed [8:0] GetCos;
    logic [6:0]        trans_read;
    logic [1:0]        demod_out;
    logic              demod_valid;
    logic              burst_active;
    logic              burst_end;
    logic [5:0]        burst_len;

    always #5 clk = ~clk;

    qam_demod #(.ACC_W(24), .THRESH(24'd65536)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .GetSin       (GetSin),
        .GetCos       (GetCos),
        .trans_read   (trans_read),
        .demod_out    (demod_out),
        .demod_valid  (demod_valid),
        .burst_active (burst_active),
        .burst_end    (burst_end),
        .burst_len    (burst_len)
    );

    typedef struct {
        bit         valid;
        logic [1:0] out;
        bit         bend;
        logic [5:0] len;
        bit         active;
        int         cyc;
    } exp_t;

    typedef struct {
        logic [1:0] sym;
        bit         rest;
        exp_t       e;
    } vec_t;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_strobe = 0;
    int   n_pushed = 0;
    exp_t expq[$];
    int   S[16];
    int   C[16];
    int   prev_mod = 0;
    bit   m_primed = 0;
    bit   m_burst = 0;
    int   m_len = 0;
    exp_t nul = '{default: 0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Strobe checker: every strobe must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (demod_valid || burst_end) n_strobe++;
        if (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            n_chk++;
            n_fail++;
            $display("FAIL missed_strobe: expected at cycle %0d",
                     e.cyc);
        end
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            chk("demod_valid", 32'(demod_valid), 32'(e.valid));
            chk("burst_end", 32'(burst_end), 32'(e.bend));
            chk("burst_active", 32'(burst_active), 32'(e.active));
            if (e.valid) chk("demod_out", 32'(demod_out), 32'(e.out));
            if (e.bend) chk("burst_len", 32'(burst_len), 32'(e.len));
        end else if (demod_valid || burst_end) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_strobe: valid=%0d end=%0d required 0",
                     demod_valid, burst_end);
        end
    end

    // Modulator: I on cosine, Q on sine; bit1 -> -I, bit0 -> +Q
    function automatic int modv(input logic [1:0] b, input int ph);
        int si;
        int sq;
        si = b[1] ? -1 : 1;
        sq = b[0] ? 1 : -1;
        return (si * C[ph % 16] + sq * S[ph % 16]) / 2;
    endfunction

    task automatic tick(input int rxv, input int ph);
        @(posedge clk);
        #1;
        rx_in      = 9'(rxv);
        GetSin     = 9'(S[ph % 16]);
        GetCos     = 9'(C[ph % 16]);
        trans_read = 7'(ph);
    endtask

    // Behavioural framing model evaluated once per completed symbol
    task automatic model(input logic [1:0] b, input bit rest,
                         input bit use_e, input exp_t te);
        exp_t m;
        bit   push;
        m = nul;
        push = 0;
        if (!rest) begin
            if (!m_burst) begin
                m_burst = 1;
                m_len = 1;
            end else if (m_len < 63) begin
                m_len++;
            end
            m.valid = 1;
            m.out = b;
            m.active = 1;
            push = 1;
        end else if (m_burst) begin
            m_burst = 0;
            m.bend = 1;
            m.len = 6'(m_len);
            push = 1;
        end
        if (use_e) begin
            m = te;
            push = te.valid || te.bend;
        end
        m.cyc = cyc + 2;
        if (push) begin
            expq.push_back(m);
            n_pushed++;
        end
    endtask

    task automatic send_sym(input logic [1:0] b, input bit rest,
                            input bit use_e, input exp_t te,
                            input bit rst_mid);
        for (int ph = 0; ph < 128; ph++) begin
            tick(prev_mod, ph);
            if (rst_mid && ph == 60) begin
                reset = 0;
                m_primed = 0;
                m_burst = 0;
                m_len = 0;
            end
            if (rst_mid && ph == 65) begin
                chk("rst_mid_out", 32'(demod_out), 0);
                chk("rst_mid_valid", 32'(demod_valid), 0);
                chk("rst_mid_active", 32'(burst_active), 0);
                chk("rst_mid_end", 32'(burst_end), 0);
                chk("rst_mid_len", 32'(burst_len), 0);
            end
            if (rst_mid && ph == 70) reset = 1;
            if (ph == 0 && reset) m_primed = 1;
            prev_mod = rest ? 0 : modv(b, ph);
            if (ph == 127 && m_primed) model(b, rest, use_e, te);
        end
    endtask

    initial begin
        vec_t tab[5];
        tab[0] = '{2'b00, 0, '{1, 2'b00, 0, 6'd0, 1, 0}};
        tab[1] = '{2'b01, 0, '{1, 2'b01, 0, 6'd0, 1, 0}};
        tab[2] = '{2'b11, 0, '{1, 2'b11, 0, 6'd0, 1, 0}};
        tab[3] = '{2'b10, 0, '{1, 2'b10, 0, 6'd0, 1, 0}};
        tab[4] = '{2'b00, 1, '{0, 2'b00, 1, 6'd4, 0, 0}};

        for (int i = 0; i < 16; i++) begin
            S[i] = $rtoi(255.0 * $sin(2.0 * 3.14159265 * i / 16.0));
            C[i] = $rtoi(255.0 * $cos(2.0 * 3.14159265 * i / 16.0));
        end

        reset = 0;
        rx_in = 0;
        GetSin = 0;
        GetCos = 0;
        trans_read = 0;

        repeat (5) begin
            @(posedge clk);
            #1;
            rx_in = 9'($urandom);
            GetSin = 9'($urandom);
            GetCos = 9'($urandom);
            trans_read = 7'($urandom);
            @(negedge clk);
            chk("reset_outputs",
                32'({demod_out, demod_valid, burst_active,
                     burst_end, burst_len}), 0);
        end

        // Release mid-window with random samples: must not emit
        for (int ph = 100; ph < 128; ph++) begin
            tick(int'($urandom_range(510)) - 255, ph);
            if (ph == 100) reset = 1;
        end
        prev_mod = 0;

        for (int i = 0; i < 5; i++) begin
            send_sym(tab[i].sym, tab[i].rest, 1, tab[i].e, 0);
        end

        for (int i = 0; i < 32; i++) begin
            send_sym(2'($urandom), 0, 0, nul, 0);
        end
        send_sym(2'b00, 1, 0, nul, 0);

        for (int i = 0; i < 8; i++) send_sym(2'b00, 1, 0, nul, 0);
        chk("silence_idle", 32'(burst_active), 0);

        for (int i = 0; i < 3; i++) send_sym(2'($urandom), 0, 0, nul, 0);
        send_sym(2'($urandom), 0, 0, nul, 1);
        for (int i = 0; i < 5; i++) send_sym(2'($urandom), 0, 0, nul, 0);
        send_sym(2'b00, 1, 0, nul, 0);

        for (int i = 0; i < 70; i++) send_sym(2'($urandom), 0, 0, nul, 0);
        send_sym(2'b00, 1, 0, nul, 0);
        send_sym(2'b00, 1, 0, nul, 0);

        chk("queue_drained", 32'(expq.size()), 0);
        chk("strobe_count", 32'(n_strobe), 32'(n_pushed));
        chk("final_idle", 32'(burst_active), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
